// File: rtl/i2c_done_flag_in_if.sv
// rtl/i2c_done_flag_in_if.sv - Avalon-MM slave register bus plus interrupt line
interface i2c_done_flag_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/i2c_done_flag_in.sv
// rtl/i2c_done_flag_in.sv - debounced I2C done/error flag input with edge capture and irq
module i2c_done_flag_in #(
  parameter int WIDTH         = 1,
  parameter int EDGE_TYPE     = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  i2c_done_flag_in_if.slave bus
);
  localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] filt_q, filt_d, dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_set, clr;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];
  logic [31:0]      rdata_q, rdata_d, rd_val;
  logic             irq_q, irq_d;
  logic             wr_en, rd_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      filt_q  <= '0;
      dly_q   <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q  <= in_port;
      sync_q  <= meta_q;
      filt_q  <= filt_d;
      dly_q   <= filt_q;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Comparing with >= rather than == keeps the counter from ever running past the limit.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = filt_q & ~dly_q;
      1:       edge_set = ~filt_q & dly_q;
      default: edge_set = filt_q ^ dly_q;
    endcase
  end

  always_comb begin
    wr_en  = bus.chipselect && !bus.write_n;
    rd_en  = bus.chipselect && !bus.read_n;
    clr    = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    // A fresh edge overrides a clear landing in the same cycle.
    cap_d  = (cap_q & ~clr) | edge_set;
    mask_d = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : mask_q;
    rd_val = '0;
    case (bus.address)
      2'd0:    rd_val[WIDTH-1:0] = filt_q;
      2'd2:    rd_val[WIDTH-1:0] = mask_q;
      2'd3:    rd_val[WIDTH-1:0] = cap_q;
      default: rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
    irq_d   = |(cap_q & mask_q);
  end

  assign bus.readdata = rdata_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_i2c_done_flag_in.sv
// tb/tb_i2c_done_flag_in.sv - scoreboard bench for i2c_done_flag_in (two parameter sets)
module tb_i2c_done_flag_in;
  logic        clk;
  logic        reset_n;
  logic        in_a;
  logic [3:0]  in_b;
  logic [31:0] exp_q [$];
  logic [31:0] got, want;
  int          n_cmp, n_err;

  i2c_done_flag_in_if bus_a ();
  i2c_done_flag_in_if bus_b ();

  i2c_done_flag_in #(.WIDTH(1), .EDGE_TYPE(0), .FILTER_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_port(in_a), .bus(bus_a)
  );
  i2c_done_flag_in #(.WIDTH(4), .EDGE_TYPE(2), .FILTER_CYCLES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_port(in_b), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit b, input logic [1:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd);
    if (b) begin
      bus_b.address = a; bus_b.chipselect = rd | wr; bus_b.read_n = ~rd;
      bus_b.write_n = ~wr; bus_b.writedata = wd;
    end else begin
      bus_a.address = a; bus_a.chipselect = rd | wr; bus_a.read_n = ~rd;
      bus_a.write_n = ~wr; bus_a.writedata = wd;
    end
  endtask

  task automatic bus_write(input bit b, input logic [1:0] a, input logic [31:0] wd);
    drive(b, a, 1'b0, 1'b1, wd);
    tick();
    drive(b, 2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bus_read(input bit b, input logic [1:0] a, input logic [31:0] e,
                          output logic [31:0] g, output logic [31:0] w);
    exp_q.push_back(e);
    drive(b, a, 1'b1, 1'b0, 32'h0);
    tick();
    g = b ? bus_b.readdata : bus_a.readdata;
    w = exp_q.pop_front();
    drive(b, 2'd0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_a = 1'b0; in_b = 4'h0;
    drive(0, 2'd0, 1'b0, 1'b0, 32'h0);
    drive(1, 2'd0, 1'b0, 1'b0, 32'h0);
    repeat (3) tick();
    n_cmp++; if ({bus_a.irq, bus_b.irq} !== 2'b00) begin
      $display("FAIL reset_irq: got %b want 00", {bus_a.irq, bus_b.irq}); n_err++; end
    n_cmp++; if (bus_a.readdata !== 32'h0 || bus_b.readdata !== 32'h0) begin
      $display("FAIL reset_rdata: got %h/%h want 0", bus_a.readdata, bus_b.readdata); n_err++; end
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      bus_read(0, 2'(i), 32'h0, got, want);
      n_cmp++; if (got !== want) begin
        $display("FAIL reset_reg%0d: got %h want %h", i, got, want); n_err++; end
    end
  endtask

  task automatic test_glitch();
    bus_write(0, 2'd2, 32'h1);
    in_a = 1'b1;
    repeat (3) tick();
    in_a = 1'b0;
    repeat (10) tick();
    n_cmp++; if (bus_a.irq !== 1'b0) begin
      $display("FAIL glitch_irq: got %b want 0", bus_a.irq); n_err++; end
    bus_read(0, 2'd0, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL glitch_data: got %h want %h", got, want); n_err++; end
    bus_read(0, 2'd3, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL glitch_cap: got %h want %h", got, want); n_err++; end
  endtask

  task automatic test_latency();
    in_a = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 7) begin
        n_cmp++; if (bus_a.irq !== 1'b0) begin
          $display("FAIL irq_early: got %b want 0 at cycle 7", bus_a.irq); n_err++; end
      end
      if (n == 8) begin
        n_cmp++; if (bus_a.irq !== 1'b1) begin
          $display("FAIL irq_latency: got %b want 1 at cycle 8", bus_a.irq); n_err++; end
      end
    end
    bus_read(0, 2'd0, 32'h1, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL lat_data: got %h want %h", got, want); n_err++; end
    bus_read(0, 2'd3, 32'h1, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL lat_cap: got %h want %h", got, want); n_err++; end
  endtask

  task automatic test_clear();
    bus_write(0, 2'd3, 32'h1);
    tick();
    n_cmp++; if (bus_a.irq !== 1'b0) begin
      $display("FAIL clr_irq: got %b want 0", bus_a.irq); n_err++; end
    bus_read(0, 2'd3, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL clr_cap: got %h want %h", got, want); n_err++; end
    in_a = 1'b0;
    repeat (10) tick();
    bus_read(0, 2'd3, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL fall_nocap: got %h want %h", got, want); n_err++; end
    in_a = 1'b1;
    repeat (6) tick();
    bus_write(0, 2'd3, 32'h1);
    bus_read(0, 2'd3, 32'h1, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL set_wins: got %h want %h", got, want); n_err++; end
  endtask

  task automatic test_mask();
    bus_write(0, 2'd2, 32'h0);
    tick();
    n_cmp++; if (bus_a.irq !== 1'b0) begin
      $display("FAIL mask0_irq: got %b want 0", bus_a.irq); n_err++; end
    bus_write(0, 2'd2, 32'h1);
    tick();
    n_cmp++; if (bus_a.irq !== 1'b1) begin
      $display("FAIL mask1_irq: got %b want 1", bus_a.irq); n_err++; end
    bus_read(0, 2'd2, 32'h1, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL mask_rd: got %h want %h", got, want); n_err++; end
  endtask

  task automatic test_any_edge();
    in_b = 4'b0100;
    repeat (10) tick();
    bus_read(1, 2'd3, 32'h4, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_rise_cap: got %h want %h", got, want); n_err++; end
    bus_read(1, 2'd0, 32'h4, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_data_hi: got %h want %h", got, want); n_err++; end
    bus_read(1, 2'd1, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_rsvd: got %h want %h", got, want); n_err++; end
    bus_write(1, 2'd3, 32'hF);
    bus_read(1, 2'd3, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_clear: got %h want %h", got, want); n_err++; end
    in_b = 4'b0000;
    repeat (10) tick();
    bus_read(1, 2'd3, 32'h4, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_fall_cap: got %h want %h", got, want); n_err++; end
    bus_write(1, 2'd0, 32'hFFFF_FFFF);
    bus_write(1, 2'd1, 32'hFFFF_FFFF);
    bus_write(1, 2'd2, 32'hFFFF_FFFF);
    bus_read(1, 2'd0, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_ro_data: got %h want %h", got, want); n_err++; end
    bus_read(1, 2'd1, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_rsvd_wr: got %h want %h", got, want); n_err++; end
    bus_read(1, 2'd2, 32'hF, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL b_mask_width: got %h want %h", got, want); n_err++; end
  endtask

  task automatic test_reset_mid_filter();
    in_a = 1'b0;
    repeat (10) tick();
    bus_write(0, 2'd3, 32'h1);
    in_a = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus_a.irq !== 1'b0 || bus_a.readdata !== 32'h0) begin
      $display("FAIL midrst_regs: got irq %b rdata %h want 0/0", bus_a.irq, bus_a.readdata); n_err++; end
    repeat (2) tick();
    reset_n = 1'b1;
    drive(0, 2'd3, 1'b1, 1'b0, 32'h0);
    for (int n = 1; n <= 8; n++) begin
      exp_q.push_back((n >= 8) ? 32'h1 : 32'h0);
      tick();
      got  = bus_a.readdata;
      want = exp_q.pop_front();
      n_cmp++; if (got !== want) begin
        $display("FAIL relcap_c%0d: got %h want %h", n, got, want); n_err++; end
    end
    drive(0, 2'd0, 1'b0, 1'b0, 32'h0);
    bus_read(0, 2'd2, 32'h0, got, want);
    n_cmp++; if (got !== want) begin $display("FAIL relmask: got %h want %h", got, want); n_err++; end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_glitch();
    test_latency();
    test_clear();
    test_mask();
    test_any_edge();
    test_reset_mid_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
